// File: rtl/halflife_pkg.sv
// Shared types and defaults for the half-life decay sequencer.
// Used by halflife_seq and halflife_prescaler.
package halflife_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DECAY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int N_DEF  = 4;
  localparam int PW_DEF = 8;

  localparam logic [3:0] HL_MAX = 4'd15;

endpackage

// File: rtl/halflife_prescaler.sv
// Decay-period prescaler: counts 0..period-1 while enabled and flags the last count.
// A period of zero is treated as one, so every enabled cycle ticks.
module halflife_prescaler
  import halflife_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [PW-1:0] period,
  output logic          tick
);

  logic [PW-1:0] cnt_r;
  logic [PW-1:0] last_s;

  // Terminal count of the prescaler; zero period collapses to a terminal count of zero
  always_comb begin
    if (period == {PW{1'b0}}) begin
      last_s = {PW{1'b0}};
    end else begin
      last_s = period - PW'(1);
    end
  end

  assign tick = enable && (cnt_r == last_s);

  // Prescaler count: wraps on tick, holds while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {PW{1'b0}};
    end else if (clear) begin
      cnt_r <= {PW{1'b0}};
    end else if (enable) begin
      if (tick) begin
        cnt_r <= {PW{1'b0}};
      end else begin
        cnt_r <= cnt_r + PW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/halflife_seq.sv
// Half-life sequencer: loads an external up/down counter, decrements it once per period
// and pulses each time the count halves. Optional pause input under HALFLIFE_SEQ_PAUSE_EN.
module halflife_seq
  import halflife_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  init_val,
  input  logic [PW-1:0] period,
  input  logic [N-1:0]  cnt_q,
`ifdef HALFLIFE_SEQ_PAUSE_EN
  input  logic          pause,
`endif
  output logic          cnt_rst,
  output logic          cnt_load,
  output logic          cnt_up,
  output logic          cnt_down,
  output logic [N-1:0]  cnt_d,
  output logic          busy,
  output logic          done,
  output logic          hl_pulse,
  output logic [3:0]    hl_count
);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [N-1:0]  init_r;
  logic [PW-1:0] period_r;
  logic [N-1:0]  ref_r;
  logic [3:0]    hl_count_r;

  logic          pause_s;
  logic          accept_s;
  logic          pre_en_s;
  logic          tick_s;
  logic [N-1:0]  nxt_s;
  logic          pulse_s;

`ifdef HALFLIFE_SEQ_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign accept_s = (state_r == ST_IDLE) && start && !abort;
  assign pre_en_s = (state_r == ST_DECAY) && !abort && !pause_s;
  assign nxt_s    = cnt_q - N'(1);
  // A half-life has elapsed once the post-tick count is at or below half the reference
  assign pulse_s  = tick_s && (nxt_s != {N{1'b0}}) && (nxt_s <= (ref_r >> 1));

  halflife_prescaler #(.PW(PW)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept_s),
    .enable (pre_en_s),
    .period (period_r),
    .tick   (tick_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (init_r == {N{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DECAY;
        end
      end
      ST_DECAY: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (tick_s && (nxt_s == {N{1'b0}})) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DECAY;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode; abort replaces the state's strobe with a counter reset
  always_comb begin
    cnt_rst  = 1'b0;
    cnt_load = 1'b0;
    cnt_up   = 1'b0;
    cnt_down = 1'b0;
    cnt_d    = {N{1'b0}};
    busy     = 1'b0;
    done     = 1'b0;
    hl_pulse = 1'b0;
    hl_count = hl_count_r;
    if (rst) begin
      cnt_rst  = 1'b1;
      hl_count = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy = 1'b0;
        end
        ST_LOAD: begin
          busy = 1'b1;
          if (abort) begin
            cnt_rst = 1'b1;
          end else begin
            cnt_load = 1'b1;
            cnt_d    = init_r;
          end
        end
        ST_DECAY: begin
          busy = 1'b1;
          if (abort) begin
            cnt_rst = 1'b1;
          end else begin
            cnt_down = tick_s;
            hl_pulse = pulse_s;
          end
        end
        ST_DONE: begin
          if (abort) begin
            cnt_rst = 1'b1;
          end else begin
            done = 1'b1;
          end
        end
        default: begin
          cnt_rst = 1'b1;
        end
      endcase
    end
  end

  // Run parameters, half-life reference and saturating half-life count
  always_ff @(posedge clk) begin
    if (rst) begin
      init_r     <= {N{1'b0}};
      period_r   <= {PW{1'b0}};
      ref_r      <= {N{1'b0}};
      hl_count_r <= 4'd0;
    end else if (accept_s) begin
      init_r     <= init_val;
      period_r   <= period;
      ref_r      <= init_val;
      hl_count_r <= 4'd0;
    end else if (pulse_s) begin
      ref_r      <= nxt_s;
      hl_count_r <= (hl_count_r == HL_MAX) ? HL_MAX : hl_count_r + 4'd1;
    end else begin
      ref_r      <= ref_r;
      hl_count_r <= hl_count_r;
    end
  end

endmodule

// File: tb/tb_halflife_seq.sv
// Self-checking bench for halflife_seq with an ideal counter attached to its strobes.
// Pause scenario is exercised only when HALFLIFE_SEQ_PAUSE_EN is defined.
module tb_halflife_seq;

  localparam int N  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, pause;
  logic [N-1:0]  init_val, cnt_q;
  logic [PW-1:0] period;
  logic          cnt_rst, cnt_load, cnt_up, cnt_down, busy, done, hl_pulse;
  logic [N-1:0]  cnt_d;
  logic [3:0]    hl_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  halflife_seq #(.N(N), .PW(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .init_val (init_val),
    .period   (period),
    .cnt_q    (cnt_q),
`ifdef HALFLIFE_SEQ_PAUSE_EN
    .pause    (pause),
`endif
    .cnt_rst  (cnt_rst),
    .cnt_load (cnt_load),
    .cnt_up   (cnt_up),
    .cnt_down (cnt_down),
    .cnt_d    (cnt_d),
    .busy     (busy),
    .done     (done),
    .hl_pulse (hl_pulse),
    .hl_count (hl_count)
  );

  // Ideal controlled counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_rst)       cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_d;
    else if (cnt_down) cnt_q <= cnt_q - 1'b1;
    else if (cnt_up)   cnt_q <= cnt_q + 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Run model: time since start decides the expected strobes
  bit m_run = 0, m_ld = 0;
  int m_el, m_tot, m_pe, m_init, m_ref, m_hl = 0;

  always @(negedge clk) begin
    int e_rst, e_load, e_d, e_down, e_busy, e_done, e_pulse, e_hl, nxt;
    bit p;
    e_rst = 0; e_load = 0; e_d = 0; e_down = 0; e_busy = 0; e_done = 0; e_pulse = 0;
    p = 1'b0;
`ifdef HALFLIFE_SEQ_PAUSE_EN
    p = pause;
`endif
    e_hl = m_hl;
    if (rst) begin
      e_rst = 1; e_hl = 0; m_hl = 0; m_run = 0;
    end else if (!m_run) begin
      if (start && !abort) begin
        m_run = 1; m_ld = 1; m_init = int'(init_val);
        m_pe = (period == 0) ? 1 : int'(period);
        m_tot = m_init * m_pe; m_el = 0; m_ref = m_init; m_hl = 0;
      end
    end else if (m_ld) begin
      e_busy = 1;
      if (abort) begin e_rst = 1; m_run = 0; end
      else begin e_load = 1; e_d = m_init; m_ld = 0; end
    end else if (m_el < m_tot) begin
      e_busy = 1;
      if (abort) begin
        e_rst = 1; m_run = 0;
      end else if (!p) begin
        if ((m_el + 1) % m_pe == 0) begin
          e_down = 1;
          nxt = m_init - (m_el + 1) / m_pe;
          if (nxt != 0 && nxt <= m_ref / 2) begin
            e_pulse = 1; m_ref = nxt; m_hl = (m_hl < 15) ? m_hl + 1 : 15;
          end
        end
        m_el++;
      end
    end else begin
      if (abort) e_rst = 1; else e_done = 1;
      m_run = 0;
    end
    if (chk_en) begin
      chk("cnt_rst", cnt_rst, e_rst);
      chk("cnt_load", cnt_load, e_load);
      chk("cnt_up", cnt_up, 0);
      chk("cnt_down", cnt_down, e_down);
      chk("cnt_d", cnt_d, e_d);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("hl_pulse", hl_pulse, e_pulse);
      chk("hl_count", hl_count, e_hl);
    end
  end

  // Event statistics for the hand-computed scenario checks
  int n_down, n_pulse, n_rst, n_done, load_cyc, done_cyc;
  int pv[3];
  always @(negedge clk) begin
    if (cnt_down) n_down++;
    if (cnt_rst) n_rst++;
    if (cnt_load) load_cyc = cyc;
    if (done) begin n_done++; done_cyc = cyc; end
    if (hl_pulse) begin
      if (n_pulse < 3) pv[n_pulse] = int'(cnt_q) - 1;
      n_pulse++;
    end
  end

  task automatic clr_stats();
    n_down = 0; n_pulse = 0; n_rst = 0; n_done = 0; load_cyc = -100; done_cyc = -1;
    for (int i = 0; i < 3; i++) pv[i] = -1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int iv, input int per);
    init_val = N'(iv); period = PW'(per);
    clr_stats();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (n_done == 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("wait_done", n_done, 1);
    step(1);
  endtask

  task automatic wait_until_downs(input int want, input int bound);
    int k;
    k = 0;
    while (n_down < want && k < bound) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("wait_downs", n_down, want);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; init_val = '0; period = '0;
    clr_stats();
    step(1);
    chk_en = 1'b1;
    step(2);
    chk("rst_cnt_rst", cnt_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_hl_count", hl_count, 0);
    rst = 1'b0;
    step(2);

    // init 8, period 2
    start_run(8, 2);
    wait_done(100);
    chk("s8p2_downs", n_down, 8);
    chk("s8p2_pulses", n_pulse, 3);
    chk("s8p2_pv0", pv[0], 4);
    chk("s8p2_pv1", pv[1], 2);
    chk("s8p2_pv2", pv[2], 1);
    chk("s8p2_done_ofs", done_cyc - (load_cyc + 1), 16);
    chk("s8p2_hl_count", hl_count, 3);

    // init 0
    start_run(0, 5);
    wait_done(20);
    chk("s0_done_ofs", done_cyc - load_cyc, 1);
    chk("s0_downs", n_down, 0);
    chk("s0_hl_count", hl_count, 0);

    // init 15, period 0
    start_run(15, 0);
    wait_done(100);
    chk("s15p0_downs", n_down, 15);
    chk("s15p0_pulses", n_pulse, 3);
    chk("s15p0_pv0", pv[0], 7);
    chk("s15p0_pv1", pv[1], 3);
    chk("s15p0_pv2", pv[2], 1);
    chk("s15p0_done_ofs", done_cyc - (load_cyc + 1), 15);
    chk("s15p0_hl_count", hl_count, 3);

    // init 8, period 3, stray start mid-run, abort after the 2nd tick
    start_run(8, 3);
    step(3);
    init_val = 4'd2; start = 1'b1;
    step(1);
    start = 1'b0;
    wait_until_downs(2, 50);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(3);
    chk("abort_rst_cnt", n_rst, 1);
    chk("abort_no_done", n_done, 0);
    chk("abort_downs", n_down, 2);
    chk("abort_busy", busy, 0);
    chk("abort_cnt_q", cnt_q, 0);

    // abort after first half-life keeps hl_count
    start_run(15, 1);
    wait_until_downs(8, 50);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(2);
    chk("abort_hl_kept", hl_count, 1);

    // abort and start together in IDLE
    init_val = 4'd5; period = 8'd1; clr_stats();
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    step(1);
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_load", n_rst + (load_cyc < 0 ? 0 : 1), 0);

    // synchronous reset mid-decay
    start_run(10, 2);
    step(4);
    rst = 1'b1;
    step(1);
    chk("midrst_cnt_rst", cnt_rst, 1);
    chk("midrst_hl", hl_count, 0);
    rst = 1'b0;
    step(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt_rst_off", cnt_rst, 0);
    step(1);

`ifdef HALFLIFE_SEQ_PAUSE_EN
    start_run(4, 2);
    wait_done(50);
    chk("nopause_ofs", done_cyc - (load_cyc + 1), 8);
    start_run(4, 2);
    step(3);
    pause = 1'b1;
    step(5);
    pause = 1'b0;
    wait_done(50);
    chk("pause_ofs", done_cyc - (load_cyc + 1), 13);
`endif

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/halflife_seq.md
HALFLIFE_SEQ -- requirements
Module: halflife_seq

Interface
REQ-001 Parameter N, default 4: width of the controlled up/down counter and its value buses.
REQ-002 Parameter PW, default 8: width of the decay-period prescaler.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  one-cycle request to begin a decay run; honoured in IDLE only.
REQ-006 abort  in  1  terminates any run.
REQ-007 init_val  in  N  start count, sampled when start is accepted.
REQ-008 period  in  PW  cycles per decrement, sampled when start is accepted.
REQ-009 cnt_q  in  N  present value of the controlled counter.
REQ-010 cnt_rst, cnt_load, cnt_up, cnt_down  out  1 each  counter control strobes.
REQ-011 cnt_d  out  N  counter load value.
REQ-012 busy  out  1  high in LOAD and DECAY.
REQ-013 done  out  1  one-cycle pulse at run completion.
REQ-014 hl_pulse  out  1  one-cycle pulse per half-life elapsed.
REQ-015 hl_count  out  4  half-lives in the current run, saturating at 15.

Function
REQ-016 States IDLE, LOAD, DECAY, DONE; IDLE->LOAD on start, LOAD->DECAY after one cycle, DECAY->DONE when counter reaches 0, DONE->IDLE after one cycle.
REQ-017 Accepting start latches init_val and period, clears hl_count and the prescaler, and sets reference ref = init_val.
REQ-018 LOAD drives cnt_load=1, cnt_d=latched init_val for exactly one cycle.
REQ-019 period of 0 behaves as 1.
REQ-020 In DECAY the prescaler counts 0..period-1; the tick cycle is prescaler == period-1, and cnt_down=1 in that cycle only.
REQ-021 cnt_up is 0 at all times.
REQ-022 On a tick, with nxt = cnt_q-1: if nxt != 0 and nxt <= ref>>1, hl_pulse=1 in the same cycle, hl_count increments (saturating), and ref <= nxt.
REQ-023 A tick with nxt == 0 gives no hl_pulse; the FSM enters DONE and done=1 for that one cycle.
REQ-024 Latched init_val of 0 goes LOAD->DONE with no cnt_down.
REQ-025 abort in any non-IDLE state: cnt_rst=1 that cycle, next state IDLE, no done pulse, hl_count retained.
REQ-026 start while not IDLE is ignored.
REQ-027 abort and start in the same IDLE cycle: abort wins.
REQ-028 No more than one of cnt_rst, cnt_load, cnt_down is high in any cycle.
REQ-029 cnt_d is 0 outside LOAD.

Reset
REQ-030 While rst is high: state IDLE; prescaler, ref and hl_count 0; cnt_rst=1; every other output 0.

Configuration
REQ-031 Macro HALFLIFE_SEQ_PAUSE_EN defined: adds input port pause (1 bit); in DECAY, pause=1 freezes the prescaler and forces cnt_down=0 and hl_pulse=0, and abort still acts.
REQ-032 Macro HALFLIFE_SEQ_PAUSE_EN undefined: no pause port exists and DECAY always advances.

Structure
REQ-033 Package halflife_pkg holds the FSM state enum and the default N and PW constants.
REQ-034 Sub-module halflife_prescaler (inputs clear, enable, period; output tick) implements REQ-019 and REQ-020.

Verification
REQ-035 init_val=8, period=2, ideal counter model: 8 cnt_down strobes 2 cycles apart; hl_pulse when the counter moves to 4, 2 and 1; done 16 cycles after DECAY entry; final hl_count=3.
REQ-036 init_val=0, start: LOAD then DONE; done=1 the next cycle; no cnt_down; hl_count=0.
REQ-037 init_val=15, period=0: cnt_down every DECAY cycle; hl_pulse at 7, 3 and 1; done after 15 ticks.
REQ-038 init_val=8, period=3, abort after the 2nd tick: cnt_rst=1 one cycle; IDLE next; no done; a start during the run is ignored.
REQ-039 rst asserted mid-DECAY: next cycle IDLE, all outputs 0 except cnt_rst=1; with HALFLIFE_SEQ_PAUSE_EN, pause held 5 cycles delays done by exactly 5 cycles.
